// File: rtl/spi_mul_frame_engine.sv
// spi_mul_frame_engine: assembles two operands from rx bytes, shift-add multiplies them, streams the product out
module spi_mul_frame_engine #(
  parameter int OP_BYTES    = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun,
  output logic       frame_err
);
  localparam int OP_W = 8 * OP_BYTES;
  localparam int FB   = 2 * OP_BYTES;
  localparam int PW   = 2 * OP_W;
  localparam int CW   = $clog2(FB) + 1;
  localparam int IW   = $clog2(OP_W) + 1;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {COLLECT, MULT, SEND} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   k;
  logic [IW-1:0]   bit_idx;
  logic [TW-1:0]   timer;
  logic [OP_W-1:0] a, b;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   addend;
  logic [CW-1:0]   sel;
  logic [7:0]      pbyte;
  logic            last_rx, timer_hit, last_bit, last_tx;
  // Partial product for the current multiplier bit and the product byte to present next
  always_comb begin
    addend    = a[bit_idx] ? (PW'(b) << bit_idx) : '0;
    sel       = tx_valid ? k + CW'(1) : k;
    pbyte     = 8'(acc >> (8 * (FB - 1 - int'(sel))));
    last_rx   = cnt == CW'(FB - 1);
    timer_hit = timer == TW'(TIMEOUT_CYC - 1);
    last_bit  = bit_idx == IW'(OP_W - 1);
    last_tx   = k == CW'(FB - 1);
  end
  // Frame FSM: collect operand bytes, run the shift-add multiply, then stream the product
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= COLLECT;
      cnt       <= '0;
      k         <= '0;
      bit_idx   <= '0;
      timer     <= '0;
      a         <= '0;
      b         <= '0;
      acc       <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (rx_valid) begin
            timer <= '0;
            if (cnt < CW'(OP_BYTES)) a <= OP_W'({a, rx_data});
            else b <= OP_W'({b, rx_data});
            cnt <= last_rx ? '0 : cnt + CW'(1);
            if (last_rx) begin
              state   <= MULT;
              busy    <= 1'b1;
              acc     <= '0;
              bit_idx <= '0;
            end
          end else if (cnt != '0) begin
            timer <= timer_hit ? '0 : timer + TW'(1);
            if (timer_hit) begin
              frame_err <= 1'b1;
              cnt       <= '0;
              a         <= '0;
              b         <= '0;
            end
          end
        end
        MULT: begin
          overrun <= rx_valid;
          acc     <= acc + addend;
          bit_idx <= bit_idx + IW'(1);
          if (last_bit) begin
            state <= SEND;
            k     <= '0;
          end
        end
        SEND: begin
          overrun <= rx_valid;
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= pbyte;
          end else if (tx_ready) begin
            tx_valid <= !last_tx;
            tx_data  <= last_tx ? '0 : pbyte;
            k        <= last_tx ? '0 : k + CW'(1);
            if (last_tx) begin
              state <= COLLECT;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= COLLECT;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mul_frame_engine.sv
// tb_spi_mul_frame_engine: table-driven and randomized checks of the serial multiplier frame engine
module tb_spi_mul_frame_engine;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, busy, overrun, frame_err;
  int         vectors = 0;
  int         miscompares = 0;
  always #5 clk = ~clk;
  spi_mul_frame_engine dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun), .frame_err(frame_err)
  );
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    int          stall_byte;
    int          stall_len;
    int          gap;
    int          ovr_at;
  } vec_t;
  vec_t tbl [10];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic send_byte(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask
  // Sends one frame, then receives and checks every product byte against the expected value
  task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                           input int stall_byte, input int stall_len, input int gap,
                           input int ovr_at, input bit rnd);
    logic [7:0] ops [4];
    logic [7:0] eb;
    logic       fe;
    int         cyc, n, st;
    ops[0] = a[15:8]; ops[1] = a[7:0]; ops[2] = b[15:8]; ops[3] = b[7:0];
    fe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3)
        for (int g = 0; g < gap; g++) begin
          tick();
          fe |= frame_err;
        end
      send_byte(ops[i]);
      fe |= frame_err;
    end
    chk("no_frame_err", 32'(fe), 32'd0);
    tx_ready = 1'b0;
    cyc = 0;
    while (!tx_valid && cyc < 100) begin
      rx_data  = 8'($urandom);
      rx_valid = (cyc == ovr_at);
      tick();
      rx_valid = 1'b0;
      if (cyc == ovr_at) chk("overrun", 32'(overrun), 32'd1);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd17);
    for (int k = 0; k < 4; k++) begin
      eb = exp[8*(3-k) +: 8];
      n = 0;
      while (!tx_valid && n < 100) begin
        tick();
        n++;
      end
      if (k > 0) chk("no_bubble", 32'(n), 32'd0);
      chk("tx_data", 32'(tx_data), 32'(eb));
      chk("busy_send", 32'(busy), 32'd1);
      st = (k == stall_byte) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < st; s++) begin
        tick();
        chk("hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, eb});
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    chk("tx_valid_done", 32'(tx_valid), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
  endtask
  initial begin
    int          cnt, pos;
    logic [15:0] ra, rb;
    tbl[0] = '{16'h0003, 16'h0005, 32'h0000000F, -1, 0, 0, -1};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, -1, 0, 0, -1};
    tbl[2] = '{16'h1234, 16'h5678, 32'h06260060, 2, 10, 0, -1};
    tbl[3] = '{16'h0002, 16'h0003, 32'h00000006, -1, 0, 0, -1};
    tbl[4] = '{16'h0009, 16'h000B, 32'h00000063, -1, 0, 0, 5};
    tbl[5] = '{16'h0007, 16'h0009, 32'h0000003F, -1, 0, 4095, -1};
    tbl[6] = '{16'h8000, 16'h8000, 32'h40000000, 1, 3, 0, 16};
    tbl[7] = '{16'h0100, 16'h00FF, 32'h0000FF00, 0, 2, 0, -1};
    tbl[8] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 3, 1, 0, 0};
    tbl[9] = '{16'h0000, 16'h1234, 32'h00000000, -1, 0, 0, -1};
    reset = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {20'd0, tx_data, tx_valid, busy, overrun, frame_err}, 32'd0);
    reset = 1'b1;
    tick();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    cnt = 0;
    pos = 0;
    for (int t = 1; t <= 4100; t++) begin
      tick();
      if (frame_err) begin
        cnt++;
        pos = t;
      end
    end
    chk("frame_err_count", 32'(cnt), 32'd1);
    chk("frame_err_time", 32'(pos), 32'd4096);
    for (int i = 0; i < 10; i++)
      run_frame(tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].stall_byte, tbl[i].stall_len,
                tbl[i].gap, tbl[i].ovr_at, 1'b0);
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h00); send_byte(8'h07);
    repeat (5) tick();
    chk("busy_mult", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    chk("reset_mid_mult", {20'd0, tx_data, tx_valid, busy, overrun, frame_err}, 32'd0);
    reset = 1'b1;
    run_frame(16'h0001, 16'h0001, 32'h00000001, -1, 0, 0, -1, 1'b0);
    for (int r = 0; r < 16; r++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_frame(ra, rb, 32'(ra) * 32'(rb), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                0, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 16)) : -1, 1'b1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
